// File: rtl/dmux_led_router_pkg.sv
// Shared widths and select encodings for the switch-to-LED demux router.
package dmux_led_router_pkg;

  localparam int DATA_W = 4;
  localparam int LED_W  = 2 * DATA_W;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/dmux_led_router_sync_chain.sv
// WIDTH x STAGES flop chain bringing board inputs into the clock domain.
// Latency STAGES edges (STAGES=0 is a wire); no backpressure.
module dmux_led_router_sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [WIDTH-1:0] chain_d [STAGES];
      logic [WIDTH-1:0] chain_q [STAGES];

      always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
          chain_d[i] = chain_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= chain_d[i];
          end
        end
      end

      assign q = chain_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/dmux_led_router.sv
// Routes the synchronised switch word onto the low or high LED nibble chosen by pba.
// Latency SYNC_STAGES+1 edges; no backpressure, led reloads every edge.
module dmux_led_router
  import dmux_led_router_pkg::*;
#(
  parameter int DATA_W      = dmux_led_router_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pba,
  input  logic [DATA_W-1:0]   sw,
  output logic [2*DATA_W-1:0] led
);

  logic                pba_s;
  logic [DATA_W-1:0]   sw_s;
  logic [2*DATA_W-1:0] led_d;
  logic [2*DATA_W-1:0] led_q;

  // Separate chains of equal depth keep select and data cycle-aligned.
  dmux_led_router_sync_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_pba_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pba),
    .q     (pba_s)
  );

  dmux_led_router_sync_chain #(
    .WIDTH  (DATA_W),
    .STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw),
    .q     (sw_s)
  );

  always_comb begin
    led_d = '0;
    if (pba_s == SEL_HI) begin
      led_d[2*DATA_W-1:DATA_W] = sw_s;
    end else begin
      led_d[DATA_W-1:0] = sw_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_dmux_led_router.sv
// Directed bench for dmux_led_router: reset, routing, latency, sweep, async reset.
module tb_dmux_led_router;

  logic       clk;
  logic       rst_n;
  logic       pba;
  logic [3:0] sw;
  logic [7:0] led;

  int errors = 0;
  int checks = 0;

  dmux_led_router #(
    .DATA_W      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pba   (pba),
    .sw    (sw),
    .led   (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: led=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp;

    rst_n = 1'b1;
    pba   = 1'b1;
    sw    = 4'b1111;
    #1 rst_n = 1'b0;
    #2 chk("reset_immediate", led, 8'h00);
    tick(3);
    chk("reset_hold", led, 8'h00);

    // Release reset and present low-route data on the same step.
    #1;
    rst_n = 1'b1;
    pba   = 1'b0;
    sw    = 4'b1010;
    tick(2);
    chk("lo_early", led, 8'h00);
    tick(1);
    chk("lo_route", led, 8'b0000_1010);

    #1;
    pba = 1'b1;
    tick(2);
    chk("hi_early", led, 8'b0000_1010);
    tick(1);
    chk("hi_route", led, 8'b1010_0000);

    // Toggle select with constant data: per-edge expectations rule out 8'h66.
    #1;
    pba = 1'b0;
    sw  = 4'b0110;
    tick(3);
    chk("toggle_lo", led, 8'h06);
    #1;
    pba = 1'b1;
    tick(1);
    chk("toggle_e1", led, 8'h06);
    tick(1);
    chk("toggle_e2", led, 8'h06);
    tick(1);
    chk("toggle_e3", led, 8'h60);
    tick(1);
    chk("toggle_e4", led, 8'h60);

    for (int i = 0; i < 32; i++) begin
      #1;
      pba = i[4];
      sw  = i[3:0];
      exp = i[4] ? {i[3:0], 4'h0} : {4'h0, i[3:0]};
      tick(3);
      chk($sformatf("sweep_%0d", i), led, exp);
    end

    // Async reset asserted between edges, then full-latency refill.
    #1;
    pba = 1'b1;
    sw  = 4'b1111;
    tick(3);
    chk("pre_areset", led, 8'hF0);
    #2;
    rst_n = 1'b0;
    #1 chk("areset_clear", led, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick(1);
    chk("refill_e1", led, 8'h00);
    tick(1);
    chk("refill_e2", led, 8'h00);
    tick(1);
    chk("refill_e3", led, 8'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
